// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell shared with the ripple-carry adder family.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/ripple_subtractor.sv
// Structural N-bit ripple subtractor: D = A - B, built from full adders (A + ~B + 1).
module ripple_subtractor
  import div_pkg::*;
#(
  parameter int N = DEF_WIDTH + 1
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] d,
  output logic         borrow
);

  logic [N:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < N; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (~b[i]),
      .cin  (carry[i]),
      .s    (d[i]),
      .cout (carry[i+1])
    );
  end

  // A missing final carry means B was larger than A.
  assign borrow = ~carry[N];

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock, start/done handshake.
// Optional DIV_ZERO_FAST_EN: a zero divisor completes in a single cycle without entering RUN.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             Start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivByZero
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0] dvs_r;
  logic [WIDTH-1:0] p_r;
  logic [WIDTH-1:0] q_sr;

  logic [WIDTH:0]   p_shift;
  logic [WIDTH:0]   t_diff;
  logic             borrow;
  logic [WIDTH-1:0] p_next;
  logic [WIDTH-1:0] q_next;
  logic             start_ok;
  logic             last_step;
  logic             unused_t_msb;

  assign start_ok  = Start && (state != RUN);
  assign last_step = (state == RUN) && (count == CW'(WIDTH - 1));

  // P' = {P, next dividend bit}; only the low WIDTH bits of P can be nonzero.
  assign p_shift = {1'b0, p_r, dvd_r[WIDTH-1]};

  ripple_subtractor #(
    .N (WIDTH + 1)
  ) u_sub (
    .a      (p_shift),
    .b      ({1'b0, dvs_r}),
    .d      (t_diff),
    .borrow (borrow)
  );

  // A successful trial subtraction leaves T below the divisor, so its top bit is zero.
  assign unused_t_msb = t_diff[WIDTH];
  assign p_next       = borrow ? p_shift[WIDTH-1:0] : t_diff[WIDTH-1:0];
  assign q_next       = {q_sr[WIDTH-2:0], ~borrow};

  // Control and result registers
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state     <= IDLE;
      count     <= '0;
      Quotient  <= '0;
      Remainder <= '0;
      DivByZero <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (Start) begin
`ifdef DIV_ZERO_FAST_EN
            if (Divisor == '0) begin
              state     <= DONE;
              Quotient  <= '1;
              Remainder <= Dividend;
              DivByZero <= 1'b1;
            end else begin
              state <= RUN;
              count <= '0;
            end
`else
            state <= RUN;
            count <= '0;
`endif
          end else if (state == DONE) begin
            state <= IDLE;
          end
        end
        RUN: begin
          count <= count + CW'(1);
          if (last_step) begin
            state     <= DONE;
            Quotient  <= q_next;
            Remainder <= p_next;
            DivByZero <= (dvs_r == '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: operand latch and shift registers
  always_ff @(posedge CLK) begin
    if (start_ok) begin
      dvd_r <= Dividend;
      dvs_r <= Divisor;
      p_r   <= '0;
      q_sr  <= '0;
    end else if (state == RUN) begin
      dvd_r <= {dvd_r[WIDTH-2:0], 1'b0};
      p_r   <= p_next;
      q_sr  <= q_next;
    end
  end

  assign Busy = (state == RUN);
  assign Done = (state == DONE);

endmodule

// File: doc/seq_restoring_divider.md
# seq_restoring_divider

Iterative unsigned restoring divider: it accepts a dividend/divisor pair on a start strobe and produces quotient and remainder one bit per clock. It is the inverse-arithmetic counterpart to the lab's ripple-carry adders and reuses the same full-adder cell, wired as a ripple subtractor, for its trial subtraction. It sits behind any datapath needing division, with a start/done handshake.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- CLK  input  1  clock; all state changes on rising edge
- RESETn  input  1  reset, synchronous, active-low
- Start  input  1  request; sampled when not in RUN
- Dividend  input  WIDTH  unsigned dividend, latched on accepted Start
- Divisor  input  WIDTH  unsigned divisor, latched on accepted Start
- Busy  output  1  high while in RUN
- Done  output  1  one-cycle pulse: results valid
- Quotient  output  WIDTH  registered quotient
- Remainder  output  WIDTH  registered remainder
- DivByZero  output  1  registered; set with Done when latched Divisor==0

## Operation
- States: IDLE, RUN, DONE.
- IDLE/DONE + Start=1 → RUN. Latch operands, clear the WIDTH+1-bit partial remainder P and the quotient shift register, set count=0.
- DONE + Start=0 → IDLE.
- Start while in RUN is ignored; there is no queueing.
- RUN step (one per cycle):
  - P' = {P[WIDTH-1:0], dividend MSB}; shift the dividend left.
  - T = P' − {0, Divisor} via ripple subtractor.
  - No borrow: P=T, shift in quotient bit 1. Borrow: P=P', shift in 0.
  - count += 1.
- After the WIDTH-th step, RUN → DONE. Quotient, Remainder = P[WIDTH-1:0], and DivByZero are registered on that same edge.
- Divisor=0 under the full algorithm yields Quotient = all ones, Remainder = Dividend, DivByZero=1.
- Quotient/Remainder/DivByZero hold until the next Done. They are not cleared by Start.
- Reset mid-operation aborts: state IDLE, no Done pulse, operands discarded.

## Timing
- Reset values: Busy=0, Done=0, Quotient=0, Remainder=0, DivByZero=0, state IDLE, count=0.
- Start accepted at edge N. Busy=1 from edge N to edge N+WIDTH. Done=1 and results valid for exactly one cycle, from edge N+WIDTH to edge N+WIDTH+1.
- Back-to-back: Start high during the Done cycle is accepted at edge N+WIDTH+1. Throughput is one division per WIDTH+1 cycles.
- Start and RESETn low on the same edge: reset wins.
- Done is never asserted on consecutive cycles.

## Configuration
- DIV_ZERO_FAST_EN defined:
  - Accepted Start with Divisor==0 goes directly to DONE at edge N.
  - Done in the cycle after edge N, latency 1.
  - Results: Quotient = all ones, Remainder = Dividend, DivByZero=1.
  - Busy stays 0 for that operation.
- Undefined: divide-by-zero runs the full WIDTH cycles with identical result values.

## Structure
- Package div_pkg:
  - state enum (IDLE, RUN, DONE)
  - default WIDTH constant
  - counter-width constant, $clog2(WIDTH+1)
- Sub-module ripple_subtractor:
  - WIDTH+1 bits, parameterised, structural.
  - Chain of existing full_adder instances; B inverted, Cin=1.
  - Outputs difference D and Borrow = ~final carry.
- Top contains the FSM, counter, and shift registers only.

## Test plan
- WIDTH=8; 100/7 → Done exactly 8 cycles after the Start edge, Quotient=14, Remainder=2, DivByZero=0.
- 255/1 → Quotient=255, Remainder=0; then 5/9 back-to-back (Start during Done) → Quotient=0, Remainder=5, accepted at edge N+9.
- 200/0 → Quotient=255, Remainder=200, DivByZero=1. Done 1 cycle after Start with DIV_ZERO_FAST_EN, 8 cycles without.
- Start 100/7, then Start 50/5 at cycle 3 of RUN → second request ignored; results 14/2, one Done pulse only.
- Start 100/7, RESETn=0 at cycle 4 → no Done, all outputs 0, Busy=0. Start 9/3 next cycle → Quotient=3, Remainder=0 after 8 cycles.
- Random 1000 pairs including 0 and 255 → results match the reference model a/b and a%b (divisor 0 per the rule above).
